tarhi_io: RTL and testbench
===========================

TARHI_IO -- requirements
Module: tarhi_io

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_write  input  1  write strobe from the tarhi core bus, valid the same cycle as mem_addr.
REQ-005 SHALL have port mem_addr  input  24  byte address from the core.
REQ-006 SHALL have port mem_din  input  32  write data from the core.
REQ-007 SHALL have port mem_dout  output  32  registered read data, to be OR-merged with the mem block's read data.
REQ-008 SHALL have port io_sel  output  1  registered; high in the cycle mem_dout carries this block's read data.
REQ-009 SHALL have port txd  output  1  UART serial transmit line, idle high.
REQ-010 SHALL have port led  output  8  general-purpose output register.

Function
REQ-011 Decode: block selected when mem_addr[23:4] == 20'hFFFF0; register = mem_addr[3:2]; mem_addr[1:0] ignored.
REQ-012 Map: 0x0 TXDATA (write-only, reads 0); 0x4 STATUS; 0x8 LED; 0xC TIMER.
REQ-013 Reads: one-cycle latency; mem_dout and io_sel update on the edge after the address is presented; when not selected, mem_dout = 0 and io_sel = 0.
REQ-014 Writes: take effect on the rising edge where selected and mem_write = 1; no wait states.
REQ-015 STATUS read = {30'b0, tx_done, tx_busy}; any write to STATUS clears tx_done.
REQ-016 LED read = {24'b0, led}; LED write loads mem_din[7:0] into led.
REQ-017 TXDATA write while tx_busy = 0 latches mem_din[7:0] and sets tx_busy on the same edge; the frame starts the next cycle.
REQ-018 TXDATA write while tx_busy = 1 SHALL be silently dropped; the frame in flight is unaffected.
REQ-019 TX FSM states: IDLE, START, DATA, STOP; IDLE->START on accepted write; START->DATA after BAUD_DIV cycles; DATA holds 8 bits LSB first, BAUD_DIV cycles each; then STOP for BAUD_DIV cycles; then IDLE.
REQ-020 txd: START = 0, DATA = current bit, STOP and IDLE = 1; total frame length exactly 10*BAUD_DIV cycles.
REQ-021 On STOP->IDLE: tx_busy clears and tx_done sets on the same edge; a new TXDATA write is accepted from the next cycle.
REQ-022 A STATUS write on the same edge tx_done sets SHALL leave tx_done = 1 (set wins).
REQ-023 Baud counter SHALL be 16 bits, reloaded at every bit boundary; no fractional accumulation.

Reset
REQ-024 reset low SHALL immediately force mem_dout = 0, io_sel = 0, txd = 1, led = 0, tx_busy = 0, tx_done = 0, FSM = IDLE, all counters = 0.
REQ-025 reset asserted mid-frame SHALL abort the frame with no further txd edges; after release the block is IDLE and accepts writes.
REQ-026 Reset release SHALL be treated as synchronous to clk by the surrounding design; the block has no internal synchroniser.

Configuration
REQ-027 Macro TARHI_IO_TIMER_EN defined: TIMER is a 32-bit free-running counter, +1 per clock, wrapping 0xFFFFFFFF->0; a write loads mem_din, and the counter increments from that value on the following edge; a read returns the value at the address cycle.
REQ-028 Macro TARHI_IO_TIMER_EN undefined: no counter logic; TIMER reads 0 and writes are ignored.

Verification (BAUD_DIV = 4)
REQ-029 Write 0xA5 to 0xFFFF00 -> txd low for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4; tx_busy high for 40 cycles; STATUS = 0x2 afterwards.
REQ-030 Second TXDATA write (0x00) 10 cycles into a frame -> ignored; the serial pattern matches a single frame; no second frame follows.
REQ-031 Write 0x3C to LED, then read 0xFFFF08 -> led = 0x3C; one cycle later mem_dout = 0x3C and io_sel = 1; read of 0x000100 -> mem_dout = 0, io_sel = 0.
REQ-032 STATUS write issued exactly on the frame-completion edge -> tx_done = 1; a STATUS write one cycle later -> tx_done = 0.
REQ-033 reset low 15 cycles into a frame -> txd = 1 and STATUS = 0 immediately; after release a write of 0xFF produces a clean 40-cycle frame.
REQ-034 With TARHI_IO_TIMER_EN: write 0xFFFFFFFE to TIMER; read it back 2 cycles later -> 0x00000000 (wrapped). Without the macro: the same read returns 0.

Source files
------------

// File: rtl/tarhi_io_if.sv
// Core-bus port bundle for the tarhi I/O block: write/address/data from the core
// and registered read data plus select going back.
interface tarhi_io_if;
    // mem_write is a one-cycle strobe that is always accepted (no ready, no wait
    // states); reads need no strobe and return on mem_dout/io_sel one edge later.
    logic        mem_write;
    logic [23:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        io_sel;

    modport master (
        output mem_write,
        output mem_addr,
        output mem_din,
        input  mem_dout,
        input  io_sel
    );

    modport slave (
        input  mem_write,
        input  mem_addr,
        input  mem_din,
        output mem_dout,
        output io_sel
    );
endinterface

// File: rtl/tarhi_io.sv
// tarhi I/O block: UART transmitter, LED register and optional free-running timer
// at 0xFFFF00..0xFFFF0C. Define TARHI_IO_TIMER_EN to build the TIMER counter.
module tarhi_io #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic          clk,
    input  logic          reset,
    tarhi_io_if.slave     bus,
    output logic          txd,
    output logic [7:0]    led,
    output logic [1:0]    tx_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    tx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        tx_busy;
    logic        tx_done;

    logic        sel;
    logic [1:0]  reg_idx;
    logic        wr_txdata;
    logic        wr_status;
    logic        wr_led;
    logic [31:0] timer_rd;
    logic [31:0] rdata;

    assign sel       = (bus.mem_addr[23:4] == 20'hFFFF0);
    assign reg_idx   = bus.mem_addr[3:2];
    assign wr_txdata = sel && bus.mem_write && (reg_idx == 2'd0);
    assign wr_status = sel && bus.mem_write && (reg_idx == 2'd1);
    assign wr_led    = sel && bus.mem_write && (reg_idx == 2'd2);
    assign tx_state  = state;

    // Byte lanes are not decoded; only the low data byte matters without the timer.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.mem_addr[1:0], bus.mem_din[31:8]};

`ifdef TARHI_IO_TIMER_EN
    logic        wr_timer;
    logic [31:0] timer;

    assign wr_timer = sel && bus.mem_write && (reg_idx == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (wr_timer) begin
            timer <= bus.mem_din;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    assign timer_rd = timer;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_idx)
            2'd0:    rdata = '0;
            2'd1:    rdata = {30'b0, tx_done, tx_busy};
            2'd2:    rdata = {24'b0, led};
            2'd3:    rdata = timer_rd;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_dout <= '0;
            bus.io_sel   <= 1'b0;
        end else begin
            bus.io_sel   <= sel;
            bus.mem_dout <= sel ? rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else if (wr_led) begin
            led <= bus.mem_din[7:0];
        end
    end

    // txd is registered: each state transition also loads the line level for
    // the following bit period, so the frame begins the cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            if (wr_status) begin
                tx_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (wr_txdata && !tx_busy) begin
                        shreg    <= bus.mem_din[7:0];
                        tx_busy  <= 1'b1;
                        baud_cnt <= BAUD_LAST;
                        txd      <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= BAUD_LAST;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_busy  <= 1'b0;
                        // Placed after the STATUS clear so a same-edge write loses.
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tarhi_io.sv
// Directed bench for tarhi_io at BAUD_DIV = 4: register map, UART frames,
// dropped writes, tx_done set-wins, mid-frame reset and the TIMER wrap.
module tb_tarhi_io;

    localparam int BAUD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       txd;
    logic [7:0] led;
    logic [1:0] tx_state;

    int checks   = 0;
    int failures = 0;

    // Expected {tx_state, txd} per cycle of a frame.
    logic [2:0] exp_q[$];

    tarhi_io_if bus ();

    tarhi_io #(.BAUD_DIV(BAUD)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .txd      (txd),
        .led      (led),
        .tx_state (tx_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_write = 1'b0;
        bus.mem_addr  = 24'h0;
        bus.mem_din   = 32'h0;
    endtask

    task automatic drive_write(input logic [23:0] addr, input logic [31:0] data);
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_din   = data;
    endtask

    task automatic write_reg(input logic [23:0] addr, input logic [31:0] data);
        drive_write(addr, data);
        step();
        bus_idle();
    endtask

    task automatic read_check(input string tag, input logic [23:0] addr,
                              input logic [31:0] exp_data, input logic exp_sel);
        bus.mem_write = 1'b0;
        bus.mem_addr  = addr;
        step();
        check_eq({tag, "_dout"}, bus.mem_dout, exp_data);
        check_eq({tag, "_sel"}, {31'b0, bus.io_sel}, {31'b0, exp_sel});
        bus_idle();
    endtask

    task automatic load_frame(input logic [7:0] data);
        exp_q.delete();
        for (int k = 0; k < 10 * BAUD; k++) begin
            if (k < BAUD)            exp_q.push_back({2'd1, 1'b0});
            else if (k < 9 * BAUD)   exp_q.push_back({2'd2, data[(k - BAUD) / BAUD]});
            else                     exp_q.push_back({2'd3, 1'b1});
        end
    endtask

    // Starts a frame, checks ncyc cycles of it, optionally drives one extra
    // write during cycle inj_at of the frame.
    task automatic run_frame(input string tag, input logic [7:0] data, input int ncyc,
                             input int inj_at, input logic [23:0] inj_addr,
                             input logic [31:0] inj_data);
        logic [2:0] e;
        drive_write(24'hFFFF00, {24'h0, data});
        step();
        load_frame(data);
        for (int k = 0; k < ncyc; k++) begin
            bus_idle();
            e = exp_q.pop_front();
            check_eq($sformatf("%s_txd_%0d", tag, k), {31'b0, txd}, {31'b0, e[0]});
            check_eq($sformatf("%s_state_%0d", tag, k), {30'b0, tx_state}, {30'b0, e[2:1]});
            if (k == inj_at) drive_write(inj_addr, inj_data);
            step();
        end
        bus_idle();
        exp_q.delete();
    endtask

    task automatic idle_line(input string tag, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            check_eq($sformatf("%s_txd_%0d", tag, k), {31'b0, txd}, 32'd1);
            check_eq($sformatf("%s_state_%0d", tag, k), {30'b0, tx_state}, 32'd0);
            step();
        end
    endtask

    initial begin
        logic [31:0] exp_t1;
        logic [31:0] exp_t2;
        bus_idle();

        // Reset state.
        #12;
        check_eq("rst_txd", {31'b0, txd}, 32'd1);
        check_eq("rst_led", {24'b0, led}, 32'd0);
        check_eq("rst_dout", bus.mem_dout, 32'd0);
        check_eq("rst_sel", {31'b0, bus.io_sel}, 32'd0);
        check_eq("rst_state", {30'b0, tx_state}, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        read_check("rd_txdata", 24'hFFFF00, 32'h0, 1'b1);
        read_check("rd_status0", 24'hFFFF04, 32'h0, 1'b1);

        // LED register and decode miss.
        write_reg(24'hFFFF08, 32'hDEAD_BE3C);
        check_eq("led_val", {24'b0, led}, 32'h3C);
        read_check("rd_led", 24'hFFFF08, 32'h3C, 1'b1);
        read_check("rd_led_alias", 24'hFFFF0B, 32'h3C, 1'b1);
        read_check("rd_miss", 24'h000100, 32'h0, 1'b0);

        // Single 0xA5 frame, then done flag.
        run_frame("a5", 8'hA5, 10 * BAUD, -1, 24'h0, 32'h0);
        read_check("st_after_a5", 24'hFFFF04, 32'h2, 1'b1);
        idle_line("idle_a5", 8);

        // Write during a frame is dropped; no second frame.
        run_frame("c3", 8'hC3, 10 * BAUD, 9, 24'hFFFF00, 32'h00);
        idle_line("idle_c3", 10 * BAUD + 4);

        // STATUS clear, then STATUS write on the completion edge: set wins.
        write_reg(24'hFFFF04, 32'h0);
        read_check("st_cleared", 24'hFFFF04, 32'h0, 1'b1);
        run_frame("81", 8'h81, 10 * BAUD, 10 * BAUD - 1, 24'hFFFF04, 32'h0);
        read_check("st_set_wins", 24'hFFFF04, 32'h2, 1'b1);
        write_reg(24'hFFFF04, 32'h0);
        read_check("st_late_clr", 24'hFFFF04, 32'h0, 1'b1);

        // Mid-frame reset: everything returns to reset values at once.
        run_frame("5a", 8'h5A, 15, -1, 24'h0, 32'h0);
        reset = 1'b0;
        #1;
        check_eq("mrst_txd", {31'b0, txd}, 32'd1);
        check_eq("mrst_state", {30'b0, tx_state}, 32'd0);
        check_eq("mrst_led", {24'b0, led}, 32'd0);
        check_eq("mrst_dout", bus.mem_dout, 32'd0);
        check_eq("mrst_sel", {31'b0, bus.io_sel}, 32'd0);
        step();
        idle_line("in_rst", 4);
        reset = 1'b1;
        read_check("st_after_rst", 24'hFFFF04, 32'h0, 1'b1);
        run_frame("ff", 8'hFF, 10 * BAUD, -1, 24'h0, 32'h0);
        read_check("st_after_ff", 24'hFFFF04, 32'h2, 1'b1);

        // TIMER load and wrap, read back on consecutive cycles.
`ifdef TARHI_IO_TIMER_EN
        exp_t1 = 32'hFFFF_FFFF;
        exp_t2 = 32'h0000_0000;
`else
        exp_t1 = 32'h0;
        exp_t2 = 32'h0;
`endif
        drive_write(24'hFFFF0C, 32'hFFFF_FFFE);
        step();
        bus_idle();
        step();
        bus.mem_addr = 24'hFFFF0C;
        step();
        check_eq("timer_plus1", bus.mem_dout, exp_t1);
        step();
        check_eq("timer_wrap", bus.mem_dout, exp_t2);
        check_eq("timer_sel", {31'b0, bus.io_sel}, 32'd1);
        bus_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
